// File: rtl/retire_checker.sv
// retire_checker: compares DUT retirements (LANES per cycle) against a golden model through two FIFOs.
// Optional feature macro RETIRE_CHK_CYCLE_STAMP_EN stamps each DUT entry with a cycle count reported on err_cycle.
module retire_checker #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STALL_LIMIT = 256,
  parameter logic [31:0] PASS_ADDR   = 32'h0C
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                chk_en,
  input  logic [LANES-1:0]    dut_valid,
  input  logic [32*LANES-1:0] dut_pc,
  input  logic [LANES-1:0]    dut_wen,
  input  logic [5*LANES-1:0]  dut_waddr,
  input  logic [32*LANES-1:0] dut_wdata,
  input  logic                ref_valid,
  input  logic                ref_wen,
  input  logic [31:0]         ref_pc,
  input  logic [31:0]         ref_wdata,
  input  logic [4:0]          ref_waddr,
  input  logic                mem_wen,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic                dut_full,
  output logic                ref_full,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic [31:0]         err_pc,
  output logic [31:0]         err_dut,
  output logic [31:0]         err_ref,
  output logic [31:0]         err_cycle,
  output logic                pass,
  output logic [31:0]         retired_cnt,
  output logic [1:0]          dbg_state
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned SW    = $clog2(STALL_LIMIT) + 1;
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  localparam logic [2:0] E_PC    = 3'd1;
  localparam logic [2:0] E_WEN   = 3'd2;
  localparam logic [2:0] E_WADDR = 3'd3;
  localparam logic [2:0] E_WDATA = 3'd4;
  localparam logic [2:0] E_STALL = 3'd5;
  localparam logic [2:0] E_OVF   = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_PASS = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  // Valid-only interface: there is no ready. Producers watch dut_full/ref_full;
  // a strobe presented while its side is full is dropped and reported as OVERFLOW.
  state_t state, state_next;

  rec_t dut_mem [DEPTH];
  rec_t ref_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] dut_wr_ptr, dut_rd_ptr, ref_wr_ptr, ref_rd_ptr;
  logic [CW-1:0]         dut_cnt, ref_cnt;
  logic [SW-1:0]         stall_cnt;

  rec_t                  lane_rec  [LANES];
  logic [ADDR_WIDTH-1:0] lane_addr [LANES];
  logic [CW-1:0]         dut_push_n;
  rec_t                  ref_rec, dut_head, ref_head;

  logic        run, dut_any, dut_push_ok, ref_push_ok, ovf, do_pop;
  logic        stall_cond, stall_err, mismatch, err_any, pass_hit;
  logic [2:0]  mis_code, fail_code;
  logic [31:0] mis_dut, mis_ref;
  logic [CW-1:0] dut_add;

`ifdef RETIRE_CHK_CYCLE_STAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] stamp_mem [DEPTH];
  logic [31:0] head_stamp;
  assign head_stamp = stamp_mem[dut_rd_ptr];
`endif

  assign run       = (state == ST_RUN);
  assign dut_full  = (DEPTH_C - dut_cnt) < LANES_C;
  assign ref_full  = (ref_cnt == DEPTH_C);
  assign err_valid = (state == ST_FAIL);
  assign pass      = (state == ST_PASS);
  assign dbg_state = state;

  assign dut_any     = |dut_valid;
  assign dut_push_ok = run && dut_any && !dut_full;
  assign ref_push_ok = run && ref_valid && !ref_full;
  assign ovf         = run && ((dut_any && dut_full) || (ref_valid && ref_full));
  assign do_pop      = run && chk_en && (dut_cnt != '0) && (ref_cnt != '0);
  assign dut_add     = dut_push_ok ? dut_push_n : '0;

  assign dut_head = dut_mem[dut_rd_ptr];
  assign ref_head = ref_mem[ref_rd_ptr];

  assign ref_rec.pc    = ref_pc;
  assign ref_rec.wen   = ref_wen;
  assign ref_rec.waddr = ref_waddr;
  assign ref_rec.wdata = ref_wdata;

  // Valid lanes are packed in lane order so a gap in dut_valid leaves no hole in the FIFO.
  always_comb begin
    dut_push_n = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i]      = dut_wr_ptr + dut_push_n[ADDR_WIDTH-1:0];
      lane_rec[i].pc    = dut_pc[32*i +: 32];
      lane_rec[i].wen   = dut_wen[i];
      lane_rec[i].waddr = dut_waddr[5*i +: 5];
      lane_rec[i].wdata = dut_wdata[32*i +: 32];
      if (dut_valid[i]) dut_push_n = dut_push_n + 1'b1;
    end
  end

  always_comb begin
    mis_code = '0;
    mis_dut  = '0;
    mis_ref  = '0;
    if (do_pop) begin
      if (dut_head.pc != ref_head.pc) begin
        mis_code = E_PC;
        mis_dut  = dut_head.pc;
        mis_ref  = ref_head.pc;
      end else if (dut_head.wen != ref_head.wen) begin
        mis_code = E_WEN;
        mis_dut  = {31'd0, dut_head.wen};
        mis_ref  = {31'd0, ref_head.wen};
      end else if (dut_head.wen && (dut_head.waddr != ref_head.waddr)) begin
        mis_code = E_WADDR;
        mis_dut  = {27'd0, dut_head.waddr};
        mis_ref  = {27'd0, ref_head.waddr};
      end else if (dut_head.wen && (dut_head.wdata != ref_head.wdata)) begin
        mis_code = E_WDATA;
        mis_dut  = dut_head.wdata;
        mis_ref  = ref_head.wdata;
      end
    end
  end

  assign mismatch   = (mis_code != '0);
  assign stall_cond = run && !do_pop && (dut_full || ref_full);
  assign stall_err  = stall_cond && (stall_cnt == STALL_LAST);
  assign pass_hit   = chk_en && mem_wen && (mem_addr == PASS_ADDR) && (mem_wdata == '0);

  always_comb begin
    fail_code = mis_code;
    if (!mismatch) begin
      if (stall_err)  fail_code = E_STALL;
      else if (ovf)   fail_code = E_OVF;
    end
  end

  assign err_any = (fail_code != '0);

  // An error outranks a same-cycle pass signature.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (err_any)       state_next = ST_FAIL;
        else if (pass_hit) state_next = ST_PASS;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state       <= ST_RUN;
      dut_wr_ptr  <= '0;
      dut_rd_ptr  <= '0;
      ref_wr_ptr  <= '0;
      ref_rd_ptr  <= '0;
      dut_cnt     <= '0;
      ref_cnt     <= '0;
      stall_cnt   <= '0;
      retired_cnt <= '0;
      err_code    <= '0;
      err_pc      <= '0;
      err_dut     <= '0;
      err_ref     <= '0;
    end else begin
      state <= state_next;
      if (dut_push_ok) dut_wr_ptr <= dut_wr_ptr + dut_push_n[ADDR_WIDTH-1:0];
      if (ref_push_ok) ref_wr_ptr <= ref_wr_ptr + 1'b1;
      if (do_pop) begin
        dut_rd_ptr <= dut_rd_ptr + 1'b1;
        ref_rd_ptr <= ref_rd_ptr + 1'b1;
      end
      dut_cnt <= dut_cnt + dut_add - CW'(do_pop);
      ref_cnt <= ref_cnt + CW'(ref_push_ok) - CW'(do_pop);
      stall_cnt <= stall_cond ? stall_cnt + 1'b1 : '0;
      if (do_pop && !mismatch) retired_cnt <= retired_cnt + 32'd1;
      if (run && err_any) begin
        err_code <= fail_code;
        err_pc   <= mismatch ? dut_head.pc : 32'd0;
        err_dut  <= mis_dut;
        err_ref  <= mis_ref;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (dut_push_ok && dut_valid[i]) dut_mem[lane_addr[i]] <= lane_rec[i];
    end
    if (ref_push_ok) ref_mem[ref_wr_ptr] <= ref_rec;
  end

`ifdef RETIRE_CHK_CYCLE_STAMP_EN
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (dut_push_ok && dut_valid[i]) stamp_mem[lane_addr[i]] <= cyc_cnt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      cyc_cnt   <= '0;
      err_cycle <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (run && err_any) err_cycle <= mismatch ? head_stamp : 32'd0;
    end
  end
`else
  assign err_cycle = '0;
`endif

endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker: one LANES=1 instance and one LANES=2 instance on a shared clock/reset.
module tb_retire_checker;

  logic sys_clk = 1'b0;
  logic sys_reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 sys_clk = ~sys_clk;

  // Instance A: LANES=1
  logic        a_chk_en;
  logic [0:0]  a_dut_valid, a_dut_wen;
  logic [31:0] a_dut_pc, a_dut_wdata;
  logic [4:0]  a_dut_waddr;
  logic        a_ref_valid, a_ref_wen;
  logic [31:0] a_ref_pc, a_ref_wdata;
  logic [4:0]  a_ref_waddr;
  logic        a_mem_wen;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic        a_dut_full, a_ref_full, a_err_valid, a_pass;
  logic [2:0]  a_err_code;
  logic [31:0] a_err_pc, a_err_dut, a_err_ref, a_err_cycle, a_retired_cnt;
  logic [1:0]  a_dbg_state;

  // Instance B: LANES=2
  logic        b_chk_en;
  logic [1:0]  b_dut_valid, b_dut_wen;
  logic [63:0] b_dut_pc, b_dut_wdata;
  logic [9:0]  b_dut_waddr;
  logic        b_ref_valid, b_ref_wen;
  logic [31:0] b_ref_pc, b_ref_wdata;
  logic [4:0]  b_ref_waddr;
  logic        b_mem_wen;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic        b_dut_full, b_ref_full, b_err_valid, b_pass;
  logic [2:0]  b_err_code;
  logic [31:0] b_err_pc, b_err_dut, b_err_ref, b_err_cycle, b_retired_cnt;
  logic [1:0]  b_dbg_state;

  retire_checker #(.LANES(1)) u_dut_a (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .chk_en(a_chk_en),
    .dut_valid(a_dut_valid), .dut_pc(a_dut_pc), .dut_wen(a_dut_wen),
    .dut_waddr(a_dut_waddr), .dut_wdata(a_dut_wdata),
    .ref_valid(a_ref_valid), .ref_wen(a_ref_wen), .ref_pc(a_ref_pc),
    .ref_wdata(a_ref_wdata), .ref_waddr(a_ref_waddr),
    .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .dut_full(a_dut_full), .ref_full(a_ref_full), .err_valid(a_err_valid),
    .err_code(a_err_code), .err_pc(a_err_pc), .err_dut(a_err_dut),
    .err_ref(a_err_ref), .err_cycle(a_err_cycle), .pass(a_pass),
    .retired_cnt(a_retired_cnt), .dbg_state(a_dbg_state)
  );

  retire_checker #(.LANES(2), .ADDR_WIDTH(8)) u_dut_b (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .chk_en(b_chk_en),
    .dut_valid(b_dut_valid), .dut_pc(b_dut_pc), .dut_wen(b_dut_wen),
    .dut_waddr(b_dut_waddr), .dut_wdata(b_dut_wdata),
    .ref_valid(b_ref_valid), .ref_wen(b_ref_wen), .ref_pc(b_ref_pc),
    .ref_wdata(b_ref_wdata), .ref_waddr(b_ref_waddr),
    .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .dut_full(b_dut_full), .ref_full(b_ref_full), .err_valid(b_err_valid),
    .err_code(b_err_code), .err_pc(b_err_pc), .err_dut(b_err_dut),
    .err_ref(b_err_ref), .err_cycle(b_err_cycle), .pass(b_pass),
    .retired_cnt(b_retired_cnt), .dbg_state(b_dbg_state)
  );

  // Entry n of a matching stream: pc=4n, wen=1, waddr=n, wdata=0x1000+n
  function automatic logic [31:0] pc_of(int n);
    return 32'(4 * n);
  endfunction
  function automatic logic [31:0] wd_of(int n);
    return 32'h1000 + 32'(n);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic a_idle();
    a_dut_valid = '0; a_dut_pc = '0; a_dut_wen = '0; a_dut_waddr = '0; a_dut_wdata = '0;
    a_ref_valid = 1'b0; a_ref_pc = '0; a_ref_wen = 1'b0; a_ref_waddr = '0; a_ref_wdata = '0;
    a_mem_wen = 1'b0; a_mem_addr = '0; a_mem_wdata = '0;
  endtask

  task automatic b_idle();
    b_dut_valid = '0; b_dut_pc = '0; b_dut_wen = '0; b_dut_waddr = '0; b_dut_wdata = '0;
    b_ref_valid = 1'b0; b_ref_pc = '0; b_ref_wen = 1'b0; b_ref_waddr = '0; b_ref_wdata = '0;
    b_mem_wen = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
  endtask

  task automatic a_push_dut(input logic [31:0] pc, input logic wen, input logic [4:0] wa,
                            input logic [31:0] wd);
    a_dut_valid = 1'b1; a_dut_pc = pc; a_dut_wen = wen; a_dut_waddr = wa; a_dut_wdata = wd;
  endtask

  task automatic a_push_ref(input logic [31:0] pc, input logic wen, input logic [4:0] wa,
                            input logic [31:0] wd);
    a_ref_valid = 1'b1; a_ref_pc = pc; a_ref_wen = wen; a_ref_waddr = wa; a_ref_wdata = wd;
  endtask

  task automatic do_reset();
    sys_reset_n = 1'b0;
    a_idle(); a_chk_en = 1'b0;
    b_idle(); b_chk_en = 1'b0;
    tick();
    tick();
    sys_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_dut_full, a_ref_full, a_err_valid, a_pass} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {a_dut_full, a_ref_full, a_err_valid, a_pass});
    end
    checks++;
    if (a_err_code !== 3'd0 || a_err_pc !== 32'd0 || a_err_dut !== 32'd0 || a_err_ref !== 32'd0 || a_err_cycle !== 32'd0) begin
      errors++; $display("FAIL reset_err: code=%0d pc=%h dut=%h ref=%h cyc=%h want all 0",
                         a_err_code, a_err_pc, a_err_dut, a_err_ref, a_err_cycle);
    end
    checks++;
    if (a_retired_cnt !== 32'd0 || b_retired_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_retired: got a=%0d b=%0d want 0", a_retired_cnt, b_retired_cnt);
    end
    checks++;
    if ({b_dut_full, b_ref_full, b_err_valid, b_pass} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags_b: got %b want 0000", {b_dut_full, b_ref_full, b_err_valid, b_pass});
    end
  endtask

  task automatic test_match();
    do_reset();
    a_chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_idle();
      a_push_dut(pc_of(k), 1'b1, 5'(k), wd_of(k));
      a_push_ref(pc_of(k), 1'b1, 5'(k), wd_of(k));
      tick();
    end
    a_idle();
    checks++;
    if (a_retired_cnt !== 32'd2) begin
      errors++; $display("FAIL match_mid: retired got %0d want 2", a_retired_cnt);
    end
    repeat (3) tick();
    checks++;
    if (a_retired_cnt !== 32'd3) begin
      errors++; $display("FAIL match_cnt: retired got %0d want 3", a_retired_cnt);
    end
    checks++;
    if (a_err_valid !== 1'b0 || a_pass !== 1'b0) begin
      errors++; $display("FAIL match_flags: err_valid=%b pass=%b want 0 0", a_err_valid, a_pass);
    end
  endtask

  task automatic test_pc_mismatch();
    do_reset();
    a_chk_en = 1'b1;
    a_push_dut(32'h14, 1'b1, 5'd2, 32'h55);
    a_push_ref(32'h10, 1'b1, 5'd2, 32'h55);
    tick();
    a_idle();
    checks++;
    if (a_err_valid !== 1'b0) begin
      errors++; $display("FAIL pc_early: err_valid got %b want 0", a_err_valid);
    end
    tick();
    checks++;
    if (a_err_valid !== 1'b1 || a_err_code !== 3'd1) begin
      errors++; $display("FAIL pc_code: valid=%b code=%0d want 1 1", a_err_valid, a_err_code);
    end
    checks++;
    if (a_err_pc !== 32'h14 || a_err_dut !== 32'h14 || a_err_ref !== 32'h10) begin
      errors++; $display("FAIL pc_fields: pc=%h dut=%h ref=%h want 14 14 10", a_err_pc, a_err_dut, a_err_ref);
    end
    a_push_dut(32'h80, 1'b0, 5'd1, 32'h1);
    a_push_ref(32'h90, 1'b1, 5'd1, 32'h1);
    tick();
    a_idle();
    repeat (3) tick();
    checks++;
    if (a_err_code !== 3'd1 || a_err_pc !== 32'h14 || a_retired_cnt !== 32'd0) begin
      errors++; $display("FAIL pc_hold: code=%0d pc=%h retired=%0d want 1 14 0", a_err_code, a_err_pc, a_retired_cnt);
    end
  endtask

  task automatic test_field_codes();
    logic [31:0] d_pc [5] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h44};
    logic        d_wen [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  d_wa [5] = '{5'd3, 5'd1, 5'd7, 5'd2, 5'd3};
    logic [31:0] d_wd [5] = '{32'hAAAA, 32'h0, 32'h1234, 32'h5, 32'h1};
    logic [31:0] r_pc [5] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
    logic        r_wen [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0]  r_wa [5] = '{5'd5, 5'd1, 5'd7, 5'd9, 5'd4};
    logic [31:0] r_wd [5] = '{32'hBBBB, 32'h0, 32'h1235, 32'h6, 32'h1};
    logic [2:0]  x_code [5] = '{3'd3, 3'd2, 3'd4, 3'd0, 3'd1};
    logic [31:0] x_dut [5] = '{32'h3, 32'h0, 32'h1234, 32'h0, 32'h44};
    logic [31:0] x_ref [5] = '{32'h5, 32'h1, 32'h1235, 32'h0, 32'h40};
    logic [31:0] x_pc [5] = '{32'h40, 32'h40, 32'h40, 32'h0, 32'h44};
    logic [31:0] x_ret [5] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      a_chk_en = 1'b1;
      a_push_dut(d_pc[i], d_wen[i], d_wa[i], d_wd[i]);
      a_push_ref(r_pc[i], r_wen[i], r_wa[i], r_wd[i]);
      tick();
      a_idle();
      tick();
      checks++;
      if (a_err_valid !== (x_code[i] != 3'd0) || a_err_code !== x_code[i] || a_err_pc !== x_pc[i]) begin
        errors++; $display("FAIL field_code[%0d]: valid=%b code=%0d pc=%h want code=%0d pc=%h",
                           i, a_err_valid, a_err_code, a_err_pc, x_code[i], x_pc[i]);
      end
      checks++;
      if (a_err_dut !== x_dut[i] || a_err_ref !== x_ref[i] || a_retired_cnt !== x_ret[i]) begin
        errors++; $display("FAIL field_data[%0d]: dut=%h ref=%h retired=%0d want %h %h %0d",
                           i, a_err_dut, a_err_ref, a_retired_cnt, x_dut[i], x_ref[i], x_ret[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_chk_en = 1'b1;
    a_push_dut(32'h100, 1'b1, 5'd1, 32'h1);
    a_push_ref(32'h200, 1'b1, 5'd1, 32'h1);
    tick();
    a_idle();
    sys_reset_n = 1'b0;
    tick();
    sys_reset_n = 1'b1;
    a_push_dut(32'h300, 1'b1, 5'd4, 32'h7);
    a_push_ref(32'h300, 1'b1, 5'd4, 32'h7);
    tick();
    a_idle();
    repeat (2) tick();
    checks++;
    if (a_err_valid !== 1'b0 || a_err_code !== 3'd0 || a_retired_cnt !== 32'd1) begin
      errors++; $display("FAIL reset_mid: valid=%b code=%0d retired=%0d want 0 0 1", a_err_valid, a_err_code, a_retired_cnt);
    end
  endtask

  task automatic test_two_lanes();
    int full_seen = 0;
    do_reset();
    b_chk_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_idle();
      if (k < 4) begin
        b_dut_valid = 2'b11;
        b_dut_wen   = 2'b11;
        b_dut_pc    = {pc_of(2*k+1), pc_of(2*k)};
        b_dut_waddr = {5'(2*k+1), 5'(2*k)};
        b_dut_wdata = {wd_of(2*k+1), wd_of(2*k)};
      end
      b_ref_valid = 1'b1; b_ref_pc = pc_of(k); b_ref_wen = 1'b1;
      b_ref_waddr = 5'(k); b_ref_wdata = wd_of(k);
      tick();
      if (b_dut_full !== 1'b0) full_seen++;
    end
    b_idle();
    repeat (3) tick();
    checks++;
    if (b_retired_cnt !== 32'd8 || b_err_valid !== 1'b0) begin
      errors++; $display("FAIL lanes2_cnt: retired=%0d err_valid=%b want 8 0", b_retired_cnt, b_err_valid);
    end
    checks++;
    if (full_seen !== 0) begin
      errors++; $display("FAIL lanes2_full: dut_full seen %0d cycles want 0", full_seen);
    end
    // Lane 1 alone, then lane 0 alone: both must land in order with no gap.
    b_dut_valid = 2'b10; b_dut_wen = 2'b11;
    b_dut_pc = {pc_of(8), 32'hDEAD_BEEF}; b_dut_waddr = {5'd8, 5'd31}; b_dut_wdata = {wd_of(8), 32'hFFFF};
    b_ref_valid = 1'b1; b_ref_pc = pc_of(8); b_ref_wen = 1'b1; b_ref_waddr = 5'd8; b_ref_wdata = wd_of(8);
    tick();
    b_dut_valid = 2'b01;
    b_dut_pc = {32'hDEAD_BEEF, pc_of(9)}; b_dut_waddr = {5'd31, 5'd9}; b_dut_wdata = {32'hFFFF, wd_of(9)};
    b_ref_pc = pc_of(9); b_ref_waddr = 5'd9; b_ref_wdata = wd_of(9);
    tick();
    b_idle();
    repeat (3) tick();
    checks++;
    if (b_retired_cnt !== 32'd10 || b_err_valid !== 1'b0) begin
      errors++; $display("FAIL lanes2_order: retired=%0d err_valid=%b code=%0d want 10 0",
                         b_retired_cnt, b_err_valid, b_err_code);
    end
  endtask

  task automatic test_stall();
    do_reset();
    a_chk_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a_idle();
      a_push_dut(pc_of(k), 1'b1, 5'(k), wd_of(k));
      if (k == 255) begin
        checks++;
        if (a_dut_full !== 1'b0) begin
          errors++; $display("FAIL stall_not_full: dut_full got %b want 0 at 255 entries", a_dut_full);
        end
      end
      tick();
    end
    a_idle();
    checks++;
    if (a_dut_full !== 1'b1 || a_err_valid !== 1'b0) begin
      errors++; $display("FAIL stall_full: dut_full=%b err_valid=%b want 1 0", a_dut_full, a_err_valid);
    end
    repeat (255) tick();
    checks++;
    if (a_err_valid !== 1'b0) begin
      errors++; $display("FAIL stall_early: err_valid got %b want 0 after 255 blocked cycles", a_err_valid);
    end
    tick();
    checks++;
    if (a_err_valid !== 1'b1 || a_err_code !== 3'd5) begin
      errors++; $display("FAIL stall_code: valid=%b code=%0d want 1 5", a_err_valid, a_err_code);
    end
    checks++;
    if (a_err_pc !== 32'd0 || a_err_dut !== 32'd0 || a_err_ref !== 32'd0) begin
      errors++; $display("FAIL stall_fields: pc=%h dut=%h ref=%h want 0 0 0", a_err_pc, a_err_dut, a_err_ref);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    a_chk_en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      a_idle();
      a_push_dut(pc_of(k), 1'b1, 5'(k), wd_of(k));
      if (k == 0) a_push_ref(pc_of(0), 1'b1, 5'd0, wd_of(0));
      tick();
    end
    a_idle();
    a_chk_en = 1'b1;
    a_push_dut(pc_of(256), 1'b1, 5'd0, wd_of(256));
    tick();
    a_idle();
    checks++;
    if (a_err_valid !== 1'b1 || a_err_code !== 3'd6 || a_err_pc !== 32'd0) begin
      errors++; $display("FAIL ovf_dut: valid=%b code=%0d pc=%h want 1 6 0", a_err_valid, a_err_code, a_err_pc);
    end
    checks++;
    if (a_retired_cnt !== 32'd1) begin
      errors++; $display("FAIL ovf_pop: retired got %0d want 1", a_retired_cnt);
    end
    do_reset();
    a_chk_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a_idle();
      a_push_ref(pc_of(k), 1'b1, 5'(k), wd_of(k));
      tick();
    end
    a_idle();
    checks++;
    if (a_ref_full !== 1'b1 || a_dut_full !== 1'b0 || a_err_valid !== 1'b0) begin
      errors++; $display("FAIL ref_full: ref_full=%b dut_full=%b err_valid=%b want 1 0 0",
                         a_ref_full, a_dut_full, a_err_valid);
    end
    a_push_ref(pc_of(256), 1'b1, 5'd0, wd_of(256));
    tick();
    a_idle();
    checks++;
    if (a_err_valid !== 1'b1 || a_err_code !== 3'd6) begin
      errors++; $display("FAIL ovf_ref: valid=%b code=%0d want 1 6", a_err_valid, a_err_code);
    end
  endtask

  task automatic test_pass();
    logic        n_chk [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        n_wen [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] n_addr [4] = '{32'h10, 32'h0C, 32'h0C, 32'h0C};
    logic [31:0] n_data [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_idle();
      a_chk_en = n_chk[i]; a_mem_wen = n_wen[i]; a_mem_addr = n_addr[i]; a_mem_wdata = n_data[i];
      tick();
      checks++;
      if (a_pass !== 1'b0) begin
        errors++; $display("FAIL pass_neg[%0d]: pass got %b want 0", i, a_pass);
      end
    end
    a_idle();
    a_chk_en = 1'b1; a_mem_wen = 1'b1; a_mem_addr = 32'h0C; a_mem_wdata = 32'h0;
    tick();
    a_idle();
    checks++;
    if (a_pass !== 1'b1 || a_err_valid !== 1'b0) begin
      errors++; $display("FAIL pass_pos: pass=%b err_valid=%b want 1 0", a_pass, a_err_valid);
    end
    a_push_dut(32'h4, 1'b1, 5'd1, 32'h1);
    a_push_ref(32'h8, 1'b1, 5'd1, 32'h1);
    tick();
    a_idle();
    repeat (3) tick();
    checks++;
    if (a_pass !== 1'b1 || a_err_valid !== 1'b0 || a_retired_cnt !== 32'd0) begin
      errors++; $display("FAIL pass_hold: pass=%b err_valid=%b retired=%0d want 1 0 0", a_pass, a_err_valid, a_retired_cnt);
    end
    // Pass signature in the same cycle as a wdata mismatch.
    do_reset();
    a_chk_en = 1'b1;
    a_push_dut(32'h20, 1'b1, 5'd6, 32'hCAFE);
    a_push_ref(32'h20, 1'b1, 5'd6, 32'hBEEF);
    tick();
    a_idle();
    a_mem_wen = 1'b1; a_mem_addr = 32'h0C; a_mem_wdata = 32'h0;
    tick();
    a_idle();
    checks++;
    if (a_err_valid !== 1'b1 || a_err_code !== 3'd4 || a_pass !== 1'b0) begin
      errors++; $display("FAIL pass_vs_err: valid=%b code=%0d pass=%b want 1 4 0", a_err_valid, a_err_code, a_pass);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_idle(); a_chk_en = 1'b0;
    b_idle(); b_chk_en = 1'b0;
    test_reset();
    test_match();
    test_pc_mismatch();
    test_field_codes();
    test_reset_mid();
    test_two_lanes();
    test_stall();
    test_overflow();
    test_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
